// File: rtl/barret_3119_arbiter.sv
// ---------------------------------------------------------------------------
// barret_3119_arbiter
//
// Purpose:
//   Shares a single combinational mod-3119 Barrett reducer among NUM_REQ
//   requesters. One requester is granted per cycle and its 23-bit operand
//   is reduced. The 12-bit residue is captured in a registered response
//   stage, tagged with the requester ID. That stage supports backpressure,
//   so one result per cycle is sustained when the consumer is ready.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous active-high reset
//   req_valid  in   NUM_REQ      per-requester operand valid
//   req_data   in   NUM_REQ*23   operands, lane i at [23*i+22:23*i]
//   req_ready  out  NUM_REQ      one-hot (or zero) grant
//   rsp_valid  out  1            response register holds a result
//   rsp_data   out  12           operand mod 3119
//   rsp_id     out  3            lane that produced rsp_data
//   rsp_ready  in   1            consumer accepts the response
//   done_cnt   out  16           completed response transfers (wrapping)
//
// Configuration:
//   BARRET_ARB_FIXED_PRIO_EN  when defined, the round-robin arbiter is
//                             replaced by fixed priority (the lowest valid
//                             index wins) and no last-grant state is kept.
//                             Undefined by default (round-robin).
// ---------------------------------------------------------------------------

// Combinational Barrett reduction of a 23-bit value modulo 3119.
// m = floor(2^24 / 3119) = 5379. The quotient estimate is off by at most
// one for every 23-bit input. A single conditional subtract therefore
// fully reduces the result.
module barret_for_3119 (
    input  logic [22:0] din_a,
    output logic [11:0] dout_r
);
    logic [11:0] qEst;
    logic [12:0] remRaw;

    // qEst * 3119 never exceeds din_a, so the difference is non-negative
    // and below 2*3119, which fits in 13 bits.
    assign qEst   = 12'((36'(din_a) * 36'd5379) >> 24);
    assign remRaw = 13'(24'(din_a) - (24'(qEst) * 24'd3119));
    assign dout_r = (remRaw >= 13'd3119) ? 12'(remRaw - 13'd3119) : remRaw[11:0];
endmodule

module barret_3119_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*23-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [11:0]           rsp_data,
    output logic [2:0]            rsp_id,
    input  logic                  rsp_ready,
    output logic [15:0]           done_cnt
);
    localparam logic [NUM_REQ-1:0] LANE0_MASK = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic               canAccept;
    logic               found;
    logic               xfer;
    logic [2:0]         grantIdx;
    logic [NUM_REQ-1:0] grantOneHot;
    logic [22:0]        operand;
    logic [11:0]        residue;

    logic               rsp_valid_q, rsp_valid_d;
    logic [11:0]        rsp_data_q,  rsp_data_d;
    logic [2:0]         rsp_id_q,    rsp_id_d;
    logic [15:0]        done_cnt_q,  done_cnt_d;
`ifndef BARRET_ARB_FIXED_PRIO_EN
    logic [2:0]         last_grant_q, last_grant_d;
`endif

    // A new result may enter the response register when it is empty or
    // is being drained in this same cycle.
    assign canAccept = !rsp_valid_q || rsp_ready;

    // Arbitration. Each candidate lane is turned into a one-hot mask
    // rather than used as a variable index. That keeps widths exact for
    // any legal NUM_REQ.
    always_comb begin
        logic [3:0]         candSum;
        logic [NUM_REQ-1:0] candMask;
        grantOneHot = '0;
        grantIdx    = '0;
        found       = 1'b0;
        candSum     = '0;
        candMask    = '0;
`ifdef BARRET_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            candMask = LANE0_MASK << k;
            if (!found && |(req_valid & candMask)) begin
                found       = 1'b1;
                grantIdx    = 3'(k);
                grantOneHot = candMask;
            end
        end
`else
        // Circular search that starts one past the previous winner.
        for (int k = 0; k < NUM_REQ; k++) begin
            candSum = {1'b0, last_grant_q} + 4'd1 + 4'(k);
            if (candSum >= 4'(NUM_REQ)) begin
                candSum = candSum - 4'(NUM_REQ);
            end
            candMask = LANE0_MASK << candSum;
            if (!found && |(req_valid & candMask)) begin
                found       = 1'b1;
                grantIdx    = candSum[2:0];
                grantOneHot = candMask;
            end
        end
`endif
    end

    // Ready is suppressed during reset and whenever the response stage
    // cannot take a new result.
    assign req_ready = (canAccept && !rst) ? grantOneHot : '0;
    assign xfer      = |(req_valid & req_ready);

    // Steer the winning operand into the shared reducer.
    always_comb begin
        operand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grantOneHot[k]) begin
                operand = req_data[23*k +: 23];
            end
        end
    end

    barret_for_3119 uReducer (
        .din_a  (operand),
        .dout_r (residue)
    );

    // Next-state logic for the response register. A drain clears valid
    // first. A same-cycle transfer then overrides that clear, so the
    // register reloads without a bubble.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        done_cnt_d  = done_cnt_q;
`ifndef BARRET_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            done_cnt_d  = done_cnt_q + 16'd1;
        end
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = residue;
            rsp_id_d    = grantIdx;
`ifndef BARRET_ARB_FIXED_PRIO_EN
            last_grant_d = grantIdx;
`endif
        end
    end

    // Reset discards any undrained response. It also points the last
    // grant at the top lane, so lane 0 has first priority afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            done_cnt_q   <= '0;
`ifndef BARRET_ARB_FIXED_PRIO_EN
            last_grant_q <= 3'(NUM_REQ - 1);
`endif
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            done_cnt_q   <= done_cnt_d;
`ifndef BARRET_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_barret_3119_arbiter.sv
// ---------------------------------------------------------------------------
// tb_barret_3119_arbiter
//
// Purpose:
//   Directed testbench for barret_3119_arbiter with NUM_REQ = 4. Inputs
//   change on the falling edge. The combinational grant is sampled 1 ns
//   after that edge, and registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_barret_3119_arbiter;
    localparam int NUM_REQ = 4;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    reqValid;
    logic [NUM_REQ*23-1:0] reqData;
    logic [NUM_REQ-1:0]    reqReady;
    logic                  rspValid;
    logic [11:0]           rspData;
    logic [2:0]            rspId;
    logic                  rspReady;
    logic [15:0]           doneCnt;

    int total = 0;
    int bad   = 0;

    barret_3119_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_data  (reqData),
        .req_ready (reqReady),
        .rsp_valid (rspValid),
        .rsp_data  (rspData),
        .rsp_id    (rspId),
        .rsp_ready (rspReady),
        .done_cnt  (doneCnt)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the lane valids and the consumer ready together.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic rr);
        reqValid = v;
        rspReady = rr;
    endtask

    // Place an operand on one lane.
    task automatic setOperand(input int lane, input int val);
        reqData[23*lane +: 23] = 23'(val);
    endtask

    // Hold reset for two edges with everything idle, then release it on a
    // falling edge.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus('0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset values. Ready must also stay low while reset is asserted,
    // even when lanes are requesting.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        #1;
        total++;
        if (reqReady !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_ready actual=%b required=0000", reqReady);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if ({rspValid, rspData, rspId, doneCnt} !== {1'b0, 12'd0, 3'd0, 16'd0}) begin
            bad++;
            $display("[TB] FAIL reset_state actual v=%b d=%0d id=%0d cnt=%0d required 0/0/0/0",
                     rspValid, rspData, rspId, doneCnt);
        end
        @(negedge clk);
        applyStimulus('0, 1'b0);
        rst = 1'b0;
        #1;
        total++;
        if (reqReady !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL idle_ready actual=%b required=0000", reqReady);
        end
    endtask

    // A single request on lane 0, with the consumer ready.
    task automatic test_single();
        doReset();
        setOperand(0, 3119);
        applyStimulus(4'b0001, 1'b1);
        #1;
        total++;
        if (reqReady !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL single_ready actual=%b required=0001", reqReady);
        end
        @(negedge clk);
        applyStimulus('0, 1'b1);
        #1;
        total++;
        if ({rspValid, rspData, rspId} !== {1'b1, 12'd0, 3'd0}) begin
            bad++;
            $display("[TB] FAIL single_rsp actual v=%b d=%0d id=%0d required 1/0/0",
                     rspValid, rspData, rspId);
        end
        total++;
        if (doneCnt !== 16'd0) begin
            bad++;
            $display("[TB] FAIL single_cnt_pre actual=%0d required=0", doneCnt);
        end
        @(posedge clk);
        #1;
        total++;
        if ({rspValid, doneCnt} !== {1'b0, 16'd1}) begin
            bad++;
            $display("[TB] FAIL single_drain actual v=%b cnt=%0d required 0/1", rspValid, doneCnt);
        end
    endtask

    // All lanes valid: the grant rotates 0,1,2,3,0 at one per cycle.
    task automatic test_round_robin();
        int          expId[5]   = '{0, 1, 2, 3, 0};
        int          expData[5] = '{0, 1, 100, 1616, 0};
        logic [3:0]  expReady;
        doReset();
        setOperand(0, 6238);
        setOperand(1, 3120);
        setOperand(2, 100);
        setOperand(3, 8388607);
        applyStimulus(4'b1111, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            expReady = 4'b0001 << expId[c];
            total++;
            if (reqReady !== expReady) begin
                bad++;
                $display("[TB] FAIL rr_ready[%0d] actual=%b required=%b", c, reqReady, expReady);
            end
            @(posedge clk);
            #1;
            total++;
            if ({rspValid, rspId, rspData} !== {1'b1, 3'(expId[c]), 12'(expData[c])}) begin
                bad++;
                $display("[TB] FAIL rr_rsp[%0d] actual v=%b id=%0d d=%0d required 1/%0d/%0d",
                         c, rspValid, rspId, rspData, expId[c], expData[c]);
            end
            @(negedge clk);
        end
        applyStimulus('0, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if ({rspValid, doneCnt} !== {1'b0, 16'd5}) begin
            bad++;
            $display("[TB] FAIL rr_done actual v=%b cnt=%0d required 0/5", rspValid, doneCnt);
        end
    endtask

    // 9999 mod 3119 = 642. The result must hold under a 3-cycle stall,
    // and then drain and reload lane 3 in the same cycle.
    task automatic test_backpressure();
        doReset();
        setOperand(2, 9999);
        applyStimulus(4'b0100, 1'b0);
        #1;
        total++;
        if (reqReady !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL bp_first_ready actual=%b required=0100", reqReady);
        end
        @(negedge clk);
        setOperand(3, 3118);
        applyStimulus(4'b1000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (reqReady !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL bp_stall_ready[%0d] actual=%b required=0000", c, reqReady);
            end
            total++;
            if ({rspValid, rspData, rspId} !== {1'b1, 12'd642, 3'd2}) begin
                bad++;
                $display("[TB] FAIL bp_hold[%0d] actual v=%b d=%0d id=%0d required 1/642/2",
                         c, rspValid, rspData, rspId);
            end
            @(negedge clk);
        end
        applyStimulus(4'b1000, 1'b1);
        #1;
        total++;
        if (reqReady !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL bp_release_ready actual=%b required=1000", reqReady);
        end
        @(posedge clk);
        #1;
        total++;
        if ({rspValid, rspData, rspId, doneCnt} !== {1'b1, 12'd3118, 3'd3, 16'd1}) begin
            bad++;
            $display("[TB] FAIL bp_reload actual v=%b d=%0d id=%0d cnt=%0d required 1/3118/3/1",
                     rspValid, rspData, rspId, doneCnt);
        end
        @(negedge clk);
        applyStimulus('0, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if ({rspValid, doneCnt} !== {1'b0, 16'd2}) begin
            bad++;
            $display("[TB] FAIL bp_final actual v=%b cnt=%0d required 0/2", rspValid, doneCnt);
        end
    endtask

    // An undrained response is discarded by reset, and arbitration
    // restarts at lane 0.
    task automatic test_reset_mid();
        doReset();
        setOperand(1, 5);
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        applyStimulus('0, 1'b0);
        #1;
        total++;
        if (rspValid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_pending actual=%b required=1", rspValid);
        end
        @(negedge clk);
        rst = 1'b1;
        setOperand(0, 3200);
        setOperand(3, 7);
        applyStimulus(4'b1001, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({rspValid, doneCnt} !== {1'b0, 16'd0}) begin
            bad++;
            $display("[TB] FAIL mid_cleared actual v=%b cnt=%0d required 0/0", rspValid, doneCnt);
        end
        total++;
        if (reqReady !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL mid_first_grant actual=%b required=0001", reqReady);
        end
        @(posedge clk);
        #1;
        total++;
        if ({rspValid, rspId, rspData} !== {1'b1, 3'd0, 12'd81}) begin
            bad++;
            $display("[TB] FAIL mid_rsp actual v=%b id=%0d d=%0d required 1/0/81",
                     rspValid, rspId, rspData);
        end
        @(negedge clk);
        #1;
        total++;
        if (reqReady !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL mid_second_grant actual=%b required=1000", reqReady);
        end
        @(negedge clk);
        applyStimulus('0, 1'b1);
        @(negedge clk);
    endtask

    // Lanes 1 and 3 are held valid. Round-robin alternates between them,
    // and fixed priority always picks lane 1.
    task automatic test_two_lanes();
        logic [3:0] expReady;
        doReset();
        setOperand(1, 3119);
        setOperand(3, 3121);
        applyStimulus(4'b1010, 1'b1);
        for (int c = 0; c < 6; c++) begin
`ifdef BARRET_ARB_FIXED_PRIO_EN
            expReady = 4'b0010;
`else
            expReady = (c % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            #1;
            total++;
            if (reqReady !== expReady) begin
                bad++;
                $display("[TB] FAIL two_ready[%0d] actual=%b required=%b", c, reqReady, expReady);
            end
            @(posedge clk);
            #1;
            total++;
            if ({rspId, rspData} !== {(expReady == 4'b0010) ? 3'd1 : 3'd3,
                                      (expReady == 4'b0010) ? 12'd0 : 12'd2}) begin
                bad++;
                $display("[TB] FAIL two_rsp[%0d] actual id=%0d d=%0d", c, rspId, rspData);
            end
            @(negedge clk);
        end
        applyStimulus('0, 1'b1);
        @(negedge clk);
    endtask

    // Lane 1 streams 65536 operands, i*128 + (i mod 128). These span 0
    // through 8388607 and wrap done_cnt.
    task automatic test_sweep();
        int op;
        doReset();
        applyStimulus(4'b0010, 1'b1);
        for (int i = 0; i < 65536; i++) begin
            op = i * 128 + (i % 128);
            setOperand(1, op);
            @(posedge clk);
            #1;
            total++;
            if ({rspValid, rspId, rspData} !== {1'b1, 3'd1, 12'(op % 3119)}) begin
                bad++;
                $display("[TB] FAIL sweep op=%0d actual v=%b id=%0d d=%0d required 1/1/%0d",
                         op, rspValid, rspId, rspData, op % 3119);
            end
            @(negedge clk);
        end
        total++;
        if (doneCnt !== 16'd65535) begin
            bad++;
            $display("[TB] FAIL sweep_cnt actual=%0d required=65535", doneCnt);
        end
        applyStimulus('0, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if ({rspValid, doneCnt} !== {1'b0, 16'd0}) begin
            bad++;
            $display("[TB] FAIL sweep_wrap actual v=%b cnt=%0d required 0/0", rspValid, doneCnt);
        end
        @(negedge clk);
        setOperand(1, 3118);
        applyStimulus(4'b0010, 1'b1);
        @(negedge clk);
        applyStimulus('0, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (doneCnt !== 16'd1) begin
            bad++;
            $display("[TB] FAIL sweep_after_wrap actual=%0d required=1", doneCnt);
        end
    endtask

    initial begin
        rst      = 1'b1;
        reqValid = '0;
        reqData  = '0;
        rspReady = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_two_lanes();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
